// File: rtl/multi_serial_loader.sv
// Operand serializer feeding the bit-serial multiplier: shifts a parallel A/B pair out
// LSB-first, appends FLUSH zero bits, and publishes frame phase, frame and done markers.
//
//   state   | meaning
//   S_IDLE  | no frame in progress, ready for an operand pair
//   S_SHIFT | operand bits on A/B, positions 0 .. WIDTH-1
//   S_FLUSH | zero bits on A/B, positions WIDTH .. WIDTH+FLUSH-1

module multi_serial_loader #(
    parameter int WIDTH = 8,
    parameter int FLUSH = 8,
    parameter int CW    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    output logic             A,
    output logic             B,
    output logic [CW-1:0]    cnt,
    output logic             BUSY,
    output logic             FRAME,
    output logic             DONE
);

    localparam int FRAME_LEN = WIDTH + FLUSH;
    localparam int PW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PW-1:0] LAST_DATA = PW'(WIDTH - 1);
    localparam logic [PW-1:0] LAST_POS  = PW'(FRAME_LEN - 1);

    if (WIDTH < 1 || FLUSH < 1) begin : g_param_check
        $error("multi_serial_loader: WIDTH must be >= 1 and FLUSH must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic             done_q, done_d;
    logic             last_flush;
    logic             accept;

    assign last_flush = (state_q == S_FLUSH) && (pos_q == LAST_POS);
    // Ready depends only on state and position so upstream can never form a loop through it.
    assign IN_READY   = (state_q == S_IDLE) || last_flush;
    assign accept     = IN_VALID && IN_READY;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                    pos_d   = '0;
                    sha_d   = IN_A;
                    shb_d   = IN_B;
                end
            end
            S_SHIFT: begin
                sha_d = sha_q >> 1;
                shb_d = shb_q >> 1;
                pos_d = pos_q + PW'(1);
                if (pos_q == LAST_DATA) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (last_flush) begin
                    done_d = 1'b1;
                    pos_d  = '0;
                    if (accept) begin
                        state_d = S_SHIFT;
                        sha_d   = IN_A;
                        shb_d   = IN_B;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                pos_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            sha_q   <= '0;
            shb_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            done_q  <= done_d;
        end
    end

    // Shift registers are empty by the time FLUSH starts, but gate anyway so idle lines stay low.
    assign A     = (state_q == S_SHIFT) && sha_q[0];
    assign B     = (state_q == S_SHIFT) && shb_q[0];
    assign BUSY  = (state_q != S_IDLE);
    assign FRAME = (state_q == S_SHIFT) && (pos_q == '0);
    assign DONE  = done_q;

    if (CW <= PW) begin : g_cnt_trunc
        assign cnt = pos_q[CW-1:0];
    end else begin : g_cnt_ext
        assign cnt = {{(CW - PW){1'b0}}, pos_q};
    end

endmodule

// File: doc/multi_serial_loader.md
Name: multi_serial_loader

Overview:
- Operand serializer that sits directly upstream of the bit-serial multiplier datapath.
- Accepts two parallel WIDTH-bit operands through a valid/ready handshake.
- Shifts both operands out LSB-first on the serial A/B lines, then drives FLUSH zero bits so the multiplier can drain the upper product bits.
- Generates the 3-bit `cnt` phase count that the multiplier's control-signal generator consumes, plus frame and done markers.

Parameters:
- WIDTH, 8: operand width in bits (serialized data bits per frame).
- FLUSH, 8: zero bits appended after the operand bits; minimum 1.
- CW, 3: width of the `cnt` phase output.

Ports:
- CLK  input  1  clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  parallel operand pair is valid.
- IN_READY  output  1  loader can accept an operand pair this cycle.
- IN_A  input  WIDTH  multiplicand, parallel.
- IN_B  input  WIDTH  multiplier, parallel.
- A  output  1  serial multiplicand bit, LSB first.
- B  output  1  serial multiplier bit, LSB first.
- cnt  output  CW  frame bit position modulo 2^CW.
- BUSY  output  1  frame in progress (SHIFT or FLUSH).
- FRAME  output  1  high during bit position 0 of a frame.
- DONE  output  1  one-cycle pulse after the last flush bit.

Behaviour:
- Reset: RST is sampled on the CLK edge only. State becomes IDLE, the position counter becomes 0, and both shift registers clear.
- Output values after reset: A=0, B=0, cnt=0, BUSY=0, FRAME=0, DONE=0, IN_READY=1.
- RST has priority over every other input, including an IN_VALID presented in the same cycle.
- All outputs except IN_READY are registered or decoded directly from registers. IN_READY is decoded from state and position only, never from IN_VALID.
- Accept: a pair is accepted on an edge where IN_VALID=1 and IN_READY=1. On that edge, IN_A/IN_B load into the shift registers, position clears to 0, and the state goes to SHIFT.
- States:
  - IDLE: A=B=0; cnt=0; BUSY=0; IN_READY=1. On accept, go to SHIFT.
  - SHIFT: A=shA[0], B=shB[0]; shift right each cycle; BUSY=1; IN_READY=0. After WIDTH cycles (position WIDTH-1), go to FLUSH.
  - FLUSH: A=B=0; BUSY=1. Runs FLUSH cycles, positions WIDTH through WIDTH+FLUSH-1. IN_READY=1 only on the last flush cycle.
    - On the last flush cycle with accept: go to SHIFT (back-to-back, no gap).
    - On the last flush cycle without accept: go to IDLE.
- Timing:
  - The first data bit (bit 0) appears on A/B in the cycle after accept. Latency from accept to bit 0 is 1 cycle.
  - One frame occupies WIDTH+FLUSH cycles.
  - Minimum accept-to-accept interval is WIDTH+FLUSH cycles.
- Position counter width is ceil(log2(WIDTH+FLUSH)). `cnt` = position modulo 2^CW, so it wraps 7→0 at the operand/flush boundary for the defaults.
- FRAME=1 exactly in the position-0 cycle of every frame, including a back-to-back frame.
- DONE=1 for exactly one cycle: the cycle following the last flush cycle. This holds whether the next state is IDLE or a new SHIFT, so DONE and FRAME coincide for back-to-back frames.
- IN_VALID while IN_READY=0 is ignored. IN_A/IN_B changes during a frame have no effect on A/B.
- Reset mid-frame aborts the frame: no DONE is produced for it, and the outputs take their reset values on the next cycle.
- Invalid parameters: FLUSH=0 or WIDTH<1 is unsupported. Elaboration must fail on either (generate-time check).

Test Plan:
1. Reset, then accept IN_A=8'hA5, IN_B=8'h3C at cycle t.
   - Cycles t+1..t+8: A=1,0,1,0,0,1,0,1 and B=0,0,1,1,1,1,0,0.
   - Cycles t+9..t+16: A=B=0.
   - cnt=0..7,0..7; FRAME=1 only at t+1; BUSY=1 over t+1..t+16.
   - DONE=1 at t+17 only; IN_READY=1 at t+16 and t+17.
2. Back-to-back: hold IN_VALID=1 with 8'hFF/8'h01, then 8'h0F/8'h80.
   - Second accept occurs on the last flush cycle of frame 1.
   - Next cycle: FRAME=1, DONE=1, cnt=0, A=1 (bit 0 of 8'h0F), B=0.
3. Pulse IN_VALID with new operands at frame position 3.
   - IN_READY=0, so the pair is not accepted.
   - Serial stream still matches the original operands.
   - Exactly one DONE is produced.
4. Assert RST for one cycle at frame position 4 of 8'hA5/8'h3C.
   - Next cycle: A=B=0, cnt=0, BUSY=0, IN_READY=1.
   - No DONE within 20 cycles.
5. Assert RST and IN_VALID together in IDLE.
   - Operand is not accepted; BUSY stays 0 the next cycle.
6. Operands 8'h00/8'h00 then 8'hFF/8'hFF.
   - First frame: all-zero A/B with a full frame timing and DONE.
   - Second frame: eight 1s on both A and B, then eight 0s.
